// File: rtl/cond_logic.sv
// cond_logic: architectural NZCV flag register plus ARM condition-field
// evaluation, gating the main decoder's write strobes so that instructions
// whose condition fails leave no side effects.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset
//   Advance   instruction-step strobe; registers update only when high
//   Cond      instruction condition field Instr[31:28]
//   ALUFlags  ALU result flags {N,Z,C,V}
//   FlagW     [1] writes N,Z  [0] writes C,V
//   PCS       PC-write request
//   RegW      register-write request
//   MemW      memory-write request
//   NoWrite   compare-type instruction, suppresses the register write
//   PCSrc     PCS & CondEx
//   RegWrite  RegW & CondEx & ~NoWrite
//   MemWrite  MemW & CondEx
//   Flags     current architectural {N,Z,C,V}
//   CondEx    condition-pass indicator (registered when CONDEX_REG=1)
module cond_logic #(
  parameter bit CONDEX_REG = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Advance,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondEx
);

  logic [3:0] flags_q;
  logic [3:0] flags_d;
  logic       condex_comb;
  logic       flag_n;
  logic       flag_z;
  logic       flag_c;
  logic       flag_v;

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

  // Condition evaluation, always against the registered flags.
  always_comb begin
    condex_comb = 1'b0;
    unique case (Cond)
      4'b0000: condex_comb = flag_z;
      4'b0001: condex_comb = ~flag_z;
      4'b0010: condex_comb = flag_c;
      4'b0011: condex_comb = ~flag_c;
      4'b0100: condex_comb = flag_n;
      4'b0101: condex_comb = ~flag_n;
      4'b0110: condex_comb = flag_v;
      4'b0111: condex_comb = ~flag_v;
      4'b1000: condex_comb = flag_c & ~flag_z;
      4'b1001: condex_comb = ~flag_c | flag_z;
      4'b1010: condex_comb = (flag_n == flag_v);
      4'b1011: condex_comb = (flag_n != flag_v);
      4'b1100: condex_comb = ~flag_z & (flag_n == flag_v);
      4'b1101: condex_comb = flag_z | (flag_n != flag_v);
      4'b1110: condex_comb = 1'b1;
      4'b1111: condex_comb = 1'b0;  // reserved encoding never executes
      default: condex_comb = 1'b0;
    endcase
  end

  // Independent N,Z and C,V write halves, only for passing instructions.
  always_comb begin
    flags_d = flags_q;
    if (Advance && FlagW[1] && condex_comb) flags_d[3:2] = ALUFlags[3:2];
    if (Advance && FlagW[0] && condex_comb) flags_d[1:0] = ALUFlags[1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flags_q <= 4'b0000;
    else        flags_q <= flags_d;
  end

  // Multicycle build holds CondEx across the instruction step.
  generate
    if (CONDEX_REG) begin : g_condex_reg
      logic condex_q;
      logic condex_d;

      always_comb begin
        condex_d = condex_q;
        if (Advance) condex_d = condex_comb;
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) condex_q <= 1'b0;
        else        condex_q <= condex_d;
      end

      assign CondEx = condex_q;
    end else begin : g_condex_comb
      assign CondEx = condex_comb;
    end
  endgenerate

  assign PCSrc    = PCS & CondEx;
  assign RegWrite = RegW & CondEx & ~NoWrite;
  assign MemWrite = MemW & CondEx;
  assign Flags    = flags_q;

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Consumer of the ALU decoder's FlagW output and the ALU's flag vector.
- Holds the architectural NZCV flag register and evaluates the 4-bit ARM condition field against it.
- Gates the main decoder's PCS/RegW/MemW write strobes so conditional instructions that fail have no side effects.
- Sits in the controller between the decoders and the datapath. Supports a single-cycle build and a multicycle build, where CondEx is held in a register.

Parameters:
- CONDEX_REG, 0: 0 = CondEx is combinational (single-cycle build); 1 = CondEx is registered (multicycle build).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Advance  in  1  instruction-step strobe; flag and CondEx registers update only when 1 (tie to 1 in single-cycle builds).
- Cond  in  4  instruction condition field, Instr[31:28].
- ALUFlags  in  4  ALU result flags {N,Z,C,V}.
- FlagW  in  2  from the ALU decoder; [1] writes N,Z and [0] writes C,V.
- PCS  in  1  PC-write request from the main decoder.
- RegW  in  1  register-write request.
- MemW  in  1  memory-write request.
- NoWrite  in  1  compare-type instruction; suppresses the register write.
- PCSrc  out  1  PCS & CondEx.
- RegWrite  out  1  RegW & CondEx & ~NoWrite.
- MemWrite  out  1  MemW & CondEx.
- Flags  out  4  current architectural {N,Z,C,V}.
- CondEx  out  1  condition-pass indicator used by the gating.

Behaviour:
- Flag register
  - 4 flops, async cleared to 4'b0000 when reset=0.
  - At each rising clk with reset=1:
    - If Advance & FlagW[1] & CondExComb: Flags[3:2] <= ALUFlags[3:2].
    - If Advance & FlagW[0] & CondExComb: Flags[1:0] <= ALUFlags[1:0].
    - Otherwise each half holds.
  - The two halves are independent; FlagW=2'b10 leaves C,V unchanged.
- Condition evaluation (CondExComb, combinational, always on the registered Flags, never on ALUFlags):
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 0 (never executes; reserved encoding must be inert)
- A failing instruction never updates flags, even with S set.
- CONDEX_REG=0:
  - CondEx = CondExComb.
  - Outputs are combinational, zero latency.
  - New flags are visible to the next instruction one cycle later.
- CONDEX_REG=1:
  - CondExReg flop, async cleared to 0; loads CondExComb on clk when Advance=1, holds otherwise.
  - CondEx = CondExReg; PCSrc/RegWrite/MemWrite use CondExReg (latency 1 from Cond).
  - Flag writes still use CondExComb in the cycle Advance is asserted.
- Reset values:
  - Flags=0000.
  - CONDEX_REG=1: CondEx=0, so PCSrc=RegWrite=MemWrite=0.
  - CONDEX_REG=0: outputs follow inputs against Flags=0000 (EQ fails, NE passes).
- Reset asserted mid-instruction: flags clear immediately (asynchronous). A flag write in progress is lost, with no partial update.
- Simultaneous flag write and condition read in the same cycle: the condition sees the old flags; the write lands at the edge.
- Advance=0: all registers hold, and the combinational gating still follows the current inputs.

Test Plan:
- Reset: assert reset=0 with ALUFlags=1111 and FlagW=11 while clocking -> Flags stays 0000. Release reset, then Cond=0000 -> CondEx=0; Cond=0001 -> CondEx=1.
- Flag halves: Cond=1110, FlagW=10, ALUFlags=1111, one edge -> Flags=1100. Then FlagW=01, ALUFlags=0011 -> Flags=1111. Then FlagW=00 -> Flags holds.
- Failed instruction suppression: Flags=0000, Cond=0000, FlagW=11, PCS=RegW=MemW=1, ALUFlags=0100 -> PCSrc=RegWrite=MemWrite=0 and Flags remains 0000 after the edge.
- Condition table sweep: for each of the 16 Flags values x 16 Cond values, check CondEx against a reference model. Spot checks: Flags=1001 with GE=1, LT=0, GT=1; Flags=0110 with HI=0, LS=1; Cond=1111 always gives 0.
- NoWrite and gating: Cond=1110, RegW=1, NoWrite=1, FlagW=11 -> RegWrite=0 and flags update. With NoWrite=0 -> RegWrite=1.
- CONDEX_REG=1:
  - Flags=0100, Cond=0000, Advance=1, edge -> CondEx=1 next cycle.
  - Then Cond=0001 with Advance=0 -> CondEx stays 1.
  - Assert Advance, edge -> CondEx=0, and MemWrite drops with MemW=1.
